hexled_bank: RTL and testbench
==============================

# hexled_bank

- Parametrised multi-digit seven-segment display controller; next generation of the single-digit hex decoder.
- Latches an N-digit hex word into a shadow register on a load strobe and drives two output forms:
  - static per-digit segment buses, for boards with one segment bus per digit;
  - one time-multiplexed segment bus with active-low digit enables, for scanned displays.
- Adds blanking, leading-zero suppression, a frame-complete pulse and optional blinking.
- Sits between the memory-mapped LED/HEX I/O register of the RISC-V core and the board pins.

## Interface

Parameters:
- NUM_DIGITS, default 8: number of hex digits (1..16).
- SCAN_DIV, default 1000: clock cycles each digit is enabled during scanning (>= 1).
- BLINK_DIV, default 25_000_000: clock cycles per blink half-period. Used only with HEXLED_BLINK_EN.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_data  input  4*NUM_DIGITS  hex word; nibble k is digit k (digit 0 = LSB, rightmost).
- i_load  input  1  when high, i_data, i_blank, i_lzs and i_blink are captured into the shadow register.
- i_blank  input  NUM_DIGITS  per-digit force-dark mask.
- i_lzs  input  1  leading-zero suppression enable.
- i_blink  input  NUM_DIGITS  per-digit blink mask. Ignored without HEXLED_BLINK_EN.
- o_hex  output  7*NUM_DIGITS  static segments; bits [7k+6:7k] are digit k. Active-low, gfedcba.
- o_seg  output  7  scanned segments, active-low, gfedcba.
- o_an  output  NUM_DIGITS  scanned digit enables, active-low one-hot.
- o_frame  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

## Operation

Shadow register:
- Loaded on every rising edge where i_load=1. i_load held high makes the shadow track the inputs every cycle.
- All display outputs derive only from the shadow, never directly from the inputs.
- Reset values: data 0, blank all ones, lzs 0, blink 0. After reset all digits are dark until the first load.

Decode (active-low gfedcba):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Dark = 1111111.

Dark rules — digit k is dark if any of the following holds:
- blank[k]=1.
- LZS: lzs=1, k>0, and every nibble from k up to NUM_DIGITS-1 is zero. Digit 0 is never LZS-suppressed.
- Blink (HEXLED_BLINK_EN only): blink[k]=1 and blink phase=1.

Scanner:
- Prescaler counts 0..SCAN_DIV-1. On the cycle it equals SCAN_DIV-1, it resets to 0 and the digit index advances modulo NUM_DIGITS.
- Index width is max(1, $clog2(NUM_DIGITS)).
- o_an = ~(1 << index). o_seg = decoded/dark-ruled value of digit [index].
- o_frame=1 for the single cycle in which the index advances from NUM_DIGITS-1 to 0.
- NUM_DIGITS=1: index stays 0, o_an=0, o_frame pulses every SCAN_DIV cycles.
- A load mid-scan does not restart the scan. New data appears on whichever digit is currently enabled.

## Timing

- All outputs are registered.
- Reset values: o_hex all ones, o_seg=1111111, o_an all ones, o_frame=0, index=0, prescaler=0.
- Latency, static path:
  - i_load sampled at edge t updates the shadow at t.
  - o_hex reflects the new shadow at edge t+1.
- Latency, scanned path: o_seg and o_an reflect index/shadow state one edge after it changes.
- First edge after reset release: o_an = ...1110, and o_seg shows digit 0 under the reset shadow (dark).
- Reset mid-operation: the next edge forces all reset values, discards the shadow contents and restarts the prescaler and index at 0.
- i_load is ignored in any cycle where i_rst=1.

## Configuration

HEXLED_BLINK_EN:
- Defined:
  - A BLINK_DIV prescaler toggles the blink phase, which is reset to 0.
  - Digits with shadow blink bit 1 go dark while phase=1, on both o_hex and o_seg.
- Undefined:
  - No blink counter or phase register is built.
  - i_blink is unused and outputs never blink.

## Test plan

- Reset: assert i_rst for 2 cycles -> o_hex all ones, o_seg=1111111, o_an=11111111, o_frame=0. After release, o_an=11111110 on the first edge.
- Static decode: N=8, load 32'h0000_12AF, blank 0, lzs 0. Two edges later:
  - digit0=0001110, digit1=0001000, digit2=0100100, digit3=1111001;
  - digits4..7=1000000.
- LZS and blank:
  - Same word with lzs=1 -> digits4..7=1111111.
  - Load 0 with lzs=1 -> only digit0=1000000.
  - blank=8'h01 -> digit0=1111111.
- Scan: N=4, SCAN_DIV=4 -> o_an cycles 1110, 1101, 1011, 0111, each held 4 cycles. o_frame pulses once every 16 cycles, coincident with the return to 1110.
- Blink, macro defined, BLINK_DIV=8, blink=4'b0010: digit1 alternates decoded/dark every 8 cycles while other digits stay steady. Macro undefined: digit1 is steady.
- Reset mid-scan at index 2: o_an=1110 on the first edge after release, prescaler restarted, all digits dark until the next load.

Source files
------------

// File: rtl/hexled_bank.sv
// hexled_bank: N-digit seven-segment driver (static + scanned); blinking built only with HEXLED_BLINK_EN
module hexled_bank #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV = 1000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic                    i_load,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  input  logic                    i_lzs,
  input  logic [NUM_DIGITS-1:0]   i_blink,
  output logic [7*NUM_DIGITS-1:0] o_hex,
  output logic [6:0]              o_seg,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [4*NUM_DIGITS-1:0] r_data;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic                    r_lzs;
  logic [PW-1:0]           r_pre;
  logic [IW-1:0]           r_idx;
  logic                    r_wrap;
  logic                    w_tick;
  logic                    w_last;
  logic                    w_zero;
  logic [NUM_DIGITS-1:0]   w_blink_dark;
  logic [6:0]              w_dig [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] w_hex;
  assign w_tick = r_pre == PW'(SCAN_DIV - 1);
  assign w_last = r_idx == IW'(NUM_DIGITS - 1);
`ifdef HEXLED_BLINK_EN
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [NUM_DIGITS-1:0] r_blink;
  logic [BW-1:0]         r_bcnt;
  logic                  r_phase;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_blink <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else begin
      if (i_load) r_blink <= i_blink;
      r_bcnt  <= (r_bcnt == BW'(BLINK_DIV - 1)) ? '0 : r_bcnt + BW'(1);
      r_phase <= (r_bcnt == BW'(BLINK_DIV - 1)) ? ~r_phase : r_phase;
    end
  assign w_blink_dark = r_phase ? r_blink : '0;
`else
  logic w_unused_blink;
  assign w_unused_blink = ^i_blink ^ (BLINK_DIV == 0);
  assign w_blink_dark = '0;
`endif
  // walk from the top digit down so w_zero means "this nibble and all above are zero"
  always_comb begin
    w_zero = 1'b1;
    w_hex = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero = w_zero & (r_data[4*k +: 4] == 4'd0);
      w_dig[k] = (r_blank[k] | (r_lzs & w_zero & (k != 0)) | w_blink_dark[k]) ? 7'h7F : SEG[r_data[4*k +: 4]];
      w_hex[7*k +: 7] = w_dig[k];
    end
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_data  <= '0;
      r_blank <= '1;
      r_lzs   <= 1'b0;
      r_pre   <= '0;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
      o_hex   <= '1;
      o_seg   <= '1;
      o_an    <= '1;
      o_frame <= 1'b0;
    end else begin
      if (i_load) begin
        r_data  <= i_data;
        r_blank <= i_blank;
        r_lzs   <= i_lzs;
      end
      r_pre   <= w_tick ? '0 : r_pre + PW'(1);
      r_idx   <= w_tick ? (w_last ? '0 : r_idx + IW'(1)) : r_idx;
      r_wrap  <= w_tick & w_last;
      o_hex   <= w_hex;
      o_seg   <= w_dig[r_idx];
      o_an    <= ~(NUM_DIGITS'(1) << r_idx);
      o_frame <= r_wrap;
    end
endmodule

// File: tb/tb_hexled_bank.sv
// tb_hexled_bank: scoreboard bench, 8-digit static/LZS checks and 4-digit scan/reset/blink checks
module tb_hexled_bank;
  logic        clk = 0;
  logic        rst = 1;
  logic        load = 0;
  logic        lzs = 0;
  logic        done = 0;
  logic [31:0] data = 0;
  logic [7:0]  blank = 0;
  logic [7:0]  blink = 0;
  logic [55:0] hex8;
  logic [27:0] hex4;
  logic [6:0]  seg8, seg4;
  logic [7:0]  an8;
  logic [3:0]  an4;
  logic        frame8, frame4;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] dig4 [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
`ifdef HEXLED_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  typedef struct {
    string       name;
    int          due;
    int          sel;
    logic [63:0] exp;
  } exp_t;
  exp_t q[$];
  hexled_bank #(.NUM_DIGITS(8), .SCAN_DIV(4), .BLINK_DIV(8)) u8 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_load(load), .i_blank(blank), .i_lzs(lzs),
    .i_blink(blink), .o_hex(hex8), .o_seg(seg8), .o_an(an8), .o_frame(frame8));
  hexled_bank #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(8)) u4 (
    .i_clk(clk), .i_rst(rst), .i_data(data[15:0]), .i_load(load), .i_blank(blank[3:0]), .i_lzs(lzs),
    .i_blink(blink[3:0]), .o_hex(hex4), .o_seg(seg4), .o_an(an4), .o_frame(frame4));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [63:0] actual(int s);
    case (s)
      0: return 64'(hex8);
      1: return 64'(seg8);
      2: return 64'(an8);
      3: return 64'(frame8);
      4: return 64'(hex4);
      5: return 64'(seg4);
      6: return 64'(an4);
      default: return 64'(frame4);
    endcase
  endfunction
  task automatic push(string n, int d, int s, logic [63:0] e);
    q.push_back('{n, d, s, e});
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin : mon
    exp_t x;
    logic [63:0] a;
    while (q.size() > 0 && q[0].due <= cyc) begin
      x = q.pop_front();
      a = actual(x.sel);
      n_cmp++;
      if (x.due != cyc || a !== x.exp) begin
        n_bad++;
        $display("FAIL %s due %0d at %0d: got %h want %h", x.name, x.due, cyc, a, x.exp);
      end
    end
    while (done && q.size() > 0) begin
      x = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s due %0d never checked: got none want %h", x.name, x.due, x.exp);
    end
  end
  task automatic ld8(string n, logic [31:0] d, logic [7:0] b, logic z, logic [55:0] e);
    data = d;
    blank = b;
    lzs = z;
    load = 1;
    push(n, cyc + 2, 0, {8'h0, e});
    tick(1);
    load = 0;
    tick(1);
  endtask
  initial begin
    int r, rr, l;
    logic [3:0] ea;
    logic [6:0] d1;
    for (int d = 1; d <= 2; d++) begin
      push("rst_hex8", d, 0, 64'h00FF_FFFF_FFFF_FFFF);
      push("rst_seg8", d, 1, 64'h7F);
      push("rst_an8", d, 2, 64'hFF);
      push("rst_frame8", d, 3, 64'h0);
      push("rst_an4", d, 6, 64'hF);
    end
    tick(2);
    rst = 0;
    push("first_hex8", 3, 0, 64'h00FF_FFFF_FFFF_FFFF);
    push("first_seg8", 3, 1, 64'h7F);
    push("first_an8", 3, 2, 64'hFE);
    push("first_an4", 3, 6, 64'hE);
    ld8("dec_12af", 32'h0000_12AF, 8'h00, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h08, 7'h0E});
    ld8("lzs_12af", 32'h0000_12AF, 8'h00, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08, 7'h0E});
    ld8("lzs_zero", 32'h0000_0000, 8'h00, 1'b1, {{7{7'h7F}}, 7'h40});
    ld8("blank_d0", 32'h0000_12AF, 8'h01, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h08, 7'h7F});
    ld8("lzs_inner", 32'h0010_0005, 8'h00, 1'b1, {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12});
    ld8("dec_bcde", 32'hBCDE_3456, 8'h00, 1'b0, {7'h03, 7'h46, 7'h21, 7'h06, 7'h30, 7'h19, 7'h12, 7'h02});
    ld8("dec_789", 32'h0000_0789, 8'h00, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78, 7'h00, 7'h10});
    ld8("blank_a0", 32'hBCDE_3456, 8'hA0, 1'b0, {7'h7F, 7'h46, 7'h7F, 7'h06, 7'h30, 7'h19, 7'h12, 7'h02});
    rst = 1;
    tick(1);
    r = cyc;
    rst = 0;
    data = 32'h0000_12AF;
    blank = 0;
    lzs = 0;
    blink = 0;
    load = 1;
    for (int e = r + 1; e <= r + 40; e++) begin
      ea = 4'b0001 << (((e - 1 - r) / 4) % 4);
      push("scan_an", e, 6, {60'h0, ~ea});
      push("scan_frame", e, 7, 64'(e > r + 1 && (e - 1 - r) % 16 == 0));
      push("scan_seg", e, 5, {57'h0, (e == r + 1) ? 7'h7F : dig4[((e - 1 - r) / 4) % 4]});
    end
    tick(1);
    load = 0;
    tick(40);
    rst = 1;
    load = 1;
    data = 32'hFFFF_FFFF;
    push("mid_rst_an4", cyc + 1, 6, 64'hF);
    push("mid_rst_seg4", cyc + 1, 5, 64'h7F);
    push("mid_rst_hex4", cyc + 1, 4, 64'hFFF_FFFF);
    push("mid_rst_frame4", cyc + 1, 7, 64'h0);
    tick(1);
    rr = cyc;
    rst = 0;
    load = 0;
    for (int e = rr + 1; e <= rr + 8; e++) begin
      push("rel_an4", e, 6, (e <= rr + 4) ? 64'hE : 64'hD);
      push("rel_hex4", e, 4, 64'hFFF_FFFF);
      push("rel_seg4", e, 5, 64'h7F);
      push("rel_frame4", e, 7, 64'h0);
    end
    tick(8);
    l = cyc;
    data = 32'h0000_12AF;
    blink = 8'h02;
    load = 1;
    for (int e = l + 2; e <= l + 33; e++) begin
      d1 = (BLINK && ((e - 1 - rr) / 8) % 2 == 1) ? 7'h7F : 7'h08;
      push("blink_hex4", e, 4, {36'h0, 7'h79, 7'h24, d1, 7'h0E});
    end
    tick(1);
    load = 0;
    blink = 0;
    tick(33);
    done = 1;
    tick(2);
    n_cmp++;
    if (hex8[6:0] !== 7'h0E) begin
      n_bad++;
      $display("FAIL end_hex8_d0: got %h want 0e", hex8[6:0]);
    end
    n_cmp++;
    if (hex8[27:21] !== 7'h79) begin
      n_bad++;
      $display("FAIL end_hex8_d3: got %h want 79", hex8[27:21]);
    end
    n_cmp++;
    if (hex4[20:14] !== 7'h24) begin
      n_bad++;
      $display("FAIL end_hex4_d2: got %h want 24", hex4[20:14]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
